// File: rtl/vp_filter_ctrl_if.sv
// Register bus between a host (master) and vp_filter_ctrl (slave).
// Single-cycle write/read strobes; read data returns one cycle later with cfg_rvalid.
interface vp_filter_ctrl_if;
  logic        cfg_wr_en;
  logic        cfg_rd_en;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;

  modport master (
    output cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_rvalid
  );

  modport slave (
    input  cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_rvalid
  );
endinterface

// File: rtl/vp_filter_ctrl.sv
// vp_filter_ctrl: frame-synchronous controller around the 3x3 median luma filter.
// Forwards the stream to the filter, selects filtered / latency-matched bypass /
// blanked luma at the output, applies CTRL only at frame starts, and measures
// line length and line count per frame (sticky HERR/VERR, frame counter).
module vp_filter_ctrl #(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int FILT_LAT  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  vp_filter_ctrl_if.slave cfg,
  input  logic            per_frame_vsync,
  input  logic            per_frame_href,
  input  logic            per_frame_clken,
  input  logic [7:0]      per_y,
  output logic            flt_frame_vsync,
  output logic            flt_frame_href,
  output logic            flt_frame_clken,
  output logic [7:0]      flt_y,
  input  logic            flt_post_vsync,
  input  logic            flt_post_href,
  input  logic            flt_post_clken,
  input  logic [7:0]      flt_post_y,
  output logic            post_frame_vsync,
  output logic            post_frame_href,
  output logic            post_frame_clken,
  output logic [7:0]      post_y
);
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_FRAME = 2'd1;
  localparam logic [1:0]  ST_LINE  = 2'd2;
  localparam logic [1:0]  ST_EOF   = 2'd3;
  localparam logic [11:0] HDISP    = 12'(IMG_HDISP);
  localparam logic [10:0] VDISP    = 11'(IMG_VDISP);

  // CTRL is kept packed as {bval[7:0], blank, en}
  logic [9:0]  ctrl_shadow_reg, ctrl_active_reg, sel_in, sel_out;
  logic [10:0] byp_out;
  logic        vs_q_reg, hs_q_reg;
  logic        vs_rise, vs_fall, hs_rise, hs_fall;
  logic        wr_ctrl, wr_status, unused_wdata;
  logic [1:0]  state_reg, state_next;
  logic [11:0] pix_cnt_reg, pix_cnt_next, last_pix_reg;
  logic [10:0] line_cnt_reg, line_cnt_next, last_lines_reg;
  logic        eol, eof;
  logic        herr_reg, verr_reg;
  logic [15:0] frame_cnt_reg;
  logic [31:0] rd_mux;

  // The filter sees the input stream untouched
  assign flt_frame_vsync = per_frame_vsync;
  assign flt_frame_href  = per_frame_href;
  assign flt_frame_clken = per_frame_clken;
  assign flt_y           = per_y;

  assign vs_rise   = per_frame_vsync & ~vs_q_reg;
  assign vs_fall   = ~per_frame_vsync & vs_q_reg;
  assign hs_rise   = per_frame_href & ~hs_q_reg;
  assign hs_fall   = ~per_frame_href & hs_q_reg;
  assign wr_ctrl   = cfg.cfg_wr_en && (cfg.cfg_addr == 2'd0);
  assign wr_status = cfg.cfg_wr_en && (cfg.cfg_addr == 2'd1);
  assign unused_wdata = ^{cfg.cfg_wdata[31:16], cfg.cfg_wdata[7:3]};

  // Sync copies reset high so a vsync already high at reset release is not taken as a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q_reg <= 1'b1;
      hs_q_reg <= 1'b1;
    end else begin
      vs_q_reg <= per_frame_vsync;
      hs_q_reg <= per_frame_href;
    end
  end

  // Shadow takes writes; active copies the pre-write shadow only at a vsync rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_shadow_reg <= 10'h001;
      ctrl_active_reg <= 10'h001;
    end else begin
      if (vs_rise)
        ctrl_active_reg <= ctrl_shadow_reg;
      if (wr_ctrl)
        ctrl_shadow_reg <= {cfg.cfg_wdata[15:8], cfg.cfg_wdata[1], cfg.cfg_wdata[0]};
    end
  end

  // Selection entering the pipe already reflects the frame that starts this cycle
  assign sel_in = vs_rise ? ctrl_shadow_reg : ctrl_active_reg;

  for (genvar gi = 0; gi < FILT_LAT; gi++) begin : g_dly
    logic [10:0] byp_reg;
    logic [9:0]  sel_reg;
    logic [10:0] byp_d;
    logic [9:0]  sel_d;
    if (gi == 0) begin : g_head
      assign byp_d = {per_frame_vsync, per_frame_href, per_frame_clken, per_y};
      assign sel_d = sel_in;
    end else begin : g_body
      assign byp_d = g_dly[gi-1].byp_reg;
      assign sel_d = g_dly[gi-1].sel_reg;
    end
    // One stage of the bypass delay line and its matching selection stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byp_reg <= '0;
        sel_reg <= '0;
      end else begin
        byp_reg <= byp_d;
        sel_reg <= sel_d;
      end
    end
  end

  assign byp_out = g_dly[FILT_LAT-1].byp_reg;
  assign sel_out = g_dly[FILT_LAT-1].sel_reg;

  // Output register: path select by EN, luma forced to BVAL when BLANK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_y           <= 8'd0;
    end else begin
      post_frame_vsync <= sel_out[0] ? flt_post_vsync : byp_out[10];
      post_frame_href  <= sel_out[0] ? flt_post_href  : byp_out[9];
      post_frame_clken <= sel_out[0] ? flt_post_clken : byp_out[8];
      post_y           <= sel_out[1] ? sel_out[9:2]
                        : (sel_out[0] ? flt_post_y : byp_out[7:0]);
    end
  end

  // Geometry FSM: next state, saturating counters and end-of-line detection
  always_comb begin
    state_next    = state_reg;
    pix_cnt_next  = pix_cnt_reg;
    line_cnt_next = line_cnt_reg;
    eol           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vs_rise) begin
          line_cnt_next = 11'd0;
          state_next    = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (vs_fall) begin
          state_next = ST_EOF;
        end else if (hs_rise) begin
          // the pixel arriving with the href rise belongs to the new line
          pix_cnt_next = {11'd0, per_frame_clken};
          state_next   = ST_LINE;
        end
      end
      ST_LINE: begin
        if (vs_fall) begin
          eol        = 1'b1;
          state_next = ST_EOF;
        end else if (hs_fall) begin
          eol        = 1'b1;
          state_next = ST_FRAME;
        end else if (per_frame_href && per_frame_clken && (pix_cnt_reg != 12'hFFF)) begin
          pix_cnt_next = pix_cnt_reg + 12'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (eol && (line_cnt_reg != 11'h7FF))
      line_cnt_next = line_cnt_reg + 11'd1;
  end

  assign eof = (state_reg == ST_EOF);

  // FSM state, counters and the line/frame measurement results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pix_cnt_reg    <= 12'd0;
      line_cnt_reg   <= 11'd0;
      last_pix_reg   <= 12'd0;
      last_lines_reg <= 11'd0;
      frame_cnt_reg  <= 16'd0;
    end else begin
      state_reg    <= state_next;
      pix_cnt_reg  <= pix_cnt_next;
      line_cnt_reg <= line_cnt_next;
      if (eol)
        last_pix_reg <= pix_cnt_reg;
      if (eof) begin
        last_lines_reg <= line_cnt_reg;
        frame_cnt_reg  <= frame_cnt_reg + 16'd1;
      end
    end
  end

  // Sticky errors: a new error in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      herr_reg <= 1'b0;
      verr_reg <= 1'b0;
    end else begin
      if (eol && (pix_cnt_reg != HDISP))
        herr_reg <= 1'b1;
      else if (wr_status && cfg.cfg_wdata[1])
        herr_reg <= 1'b0;
      if (eof && (line_cnt_reg != VDISP))
        verr_reg <= 1'b1;
      else if (wr_status && cfg.cfg_wdata[2])
        verr_reg <= 1'b0;
    end
  end

  // Register read decode
  always_comb begin
    rd_mux = 32'd0;
    case (cfg.cfg_addr)
      2'd0:    rd_mux = {16'd0, ctrl_shadow_reg[9:2], 6'd0, ctrl_shadow_reg[1:0]};
      2'd1:    rd_mux = {frame_cnt_reg, 13'd0, verr_reg, herr_reg, per_frame_vsync};
      2'd2:    rd_mux = {5'd0, last_lines_reg, 4'd0, last_pix_reg};
      default: rd_mux = 32'd0;
    endcase
  end

  // Read response: data sampled in the strobe cycle, returned one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_rdata  <= 32'd0;
      cfg.cfg_rvalid <= 1'b0;
    end else begin
      cfg.cfg_rvalid <= cfg.cfg_rd_en;
      if (cfg.cfg_rd_en)
        cfg.cfg_rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_vp_filter_ctrl.sv
// Scoreboard bench for vp_filter_ctrl with an 8x4 frame geometry and a 3-cycle
// filter model (output luma = inverted input) so the paths are distinguishable.
module tb_vp_filter_ctrl;
  localparam int HD  = 8;
  localparam int VD  = 4;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic [7:0] per_y = 8'd0;
  logic       flt_frame_vsync, flt_frame_href, flt_frame_clken;
  logic [7:0] flt_y;
  logic       flt_post_vsync, flt_post_href, flt_post_clken;
  logic [7:0] flt_post_y;
  logic       post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0] post_y;

  vp_filter_ctrl_if cfg_bus();

  vp_filter_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .FILT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_bus),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_y(per_y),
    .flt_frame_vsync(flt_frame_vsync), .flt_frame_href(flt_frame_href),
    .flt_frame_clken(flt_frame_clken), .flt_y(flt_y),
    .flt_post_vsync(flt_post_vsync), .flt_post_href(flt_post_href),
    .flt_post_clken(flt_post_clken), .flt_post_y(flt_post_y),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_y(post_y)
  );

  always #5 clk = ~clk;

  // Filter model: 3-cycle delay, luma inverted
  logic [10:0] fm0 = '0, fm1 = '0, fm2 = '0;
  always @(posedge clk) begin
    fm0 <= {flt_frame_vsync, flt_frame_href, flt_frame_clken, flt_y};
    fm1 <= fm0;
    fm2 <= fm1;
  end
  assign flt_post_vsync = fm2[10];
  assign flt_post_href  = fm2[9];
  assign flt_post_clken = fm2[8];
  assign flt_post_y     = ~fm2[7:0];

  typedef struct { logic [7:0] y; int cyc; } pix_t;
  pix_t        pix_q[$];
  int          vs_q[$];
  logic [31:0] rd_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          frame_no = 0;
  logic [31:0] tb_shadow = 32'h1;
  logic [31:0] exp_active = 32'h1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT presents a pixel, a vsync rise or a read response
  initial begin
    pix_t e;
    int   ev;
    logic [31:0] er;
    logic vs_prev;
    vs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (post_frame_clken) begin
          total++;
          if (pix_q.size() == 0) begin
            bad++;
            $display("FAIL pix_unexpected: got y=%02h at cyc %0d, required no pixel", post_y, cyc);
          end else begin
            e = pix_q.pop_front();
            if (post_y !== e.y || cyc != e.cyc || post_frame_href !== 1'b1) begin
              bad++;
              $display("FAIL pix: got y=%02h href=%0b cyc=%0d, required y=%02h href=1 cyc=%0d",
                       post_y, post_frame_href, cyc, e.y, e.cyc);
            end
          end
        end
        if (post_frame_vsync && !vs_prev) begin
          total++;
          if (vs_q.size() == 0) begin
            bad++;
            $display("FAIL vsync_rise_unexpected: got rise at cyc %0d, required none", cyc);
          end else begin
            ev = vs_q.pop_front();
            if (cyc != ev) begin
              bad++;
              $display("FAIL vsync_rise: got cyc %0d, required cyc %0d", cyc, ev);
            end
          end
        end
        if (cfg_bus.cfg_rvalid) begin
          total++;
          if (rd_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected: got rdata=%08h, required no response", cfg_bus.cfg_rdata);
          end else begin
            er = rd_q.pop_front();
            if (cfg_bus.cfg_rdata !== er) begin
              bad++;
              $display("FAIL rd_data: got %08h, required %08h", cfg_bus.cfg_rdata, er);
            end else begin
              $display("read ok: %08h", er);
            end
          end
        end
      end
      vs_prev = post_frame_vsync;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_y(input logic [31:0] c, input logic [7:0] y);
    if (c[1]) return c[15:8];
    else if (c[0]) return ~y;
    else return y;
  endfunction

  task automatic cfg_read(input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    cfg_bus.cfg_rd_en = 1'b1;
    cfg_bus.cfg_addr  = a;
    tick();
    cfg_bus.cfg_rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_bus.cfg_wr_en = 1'b1;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_wdata = d;
    if (a == 2'd0) tb_shadow = d & 32'h0000_FF03;
    tick();
    cfg_bus.cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp);
    rd_q.push_back(exp);
    cfg_bus.cfg_rd_en = 1'b1;
    cfg_bus.cfg_wr_en = 1'b1;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_wdata = d;
    tick();
    cfg_bus.cfg_rd_en = 1'b0;
    cfg_bus.cfg_wr_en = 1'b0;
    tick();
    tick();
  endtask

  // One frame; optional short line and optional register write in the first gap cycle after line wr_line
  task automatic drive_frame(input int nlines, input int short_line, input int short_len,
                             input int wr_line, input logic [1:0] wa, input logic [31:0] wd);
    int   len;
    pix_t e;
    $display("frame %0d: lines=%0d short_line=%0d ctrl=%08h", frame_no, nlines, short_line, tb_shadow);
    per_frame_vsync = 1'b1;
    exp_active = tb_shadow;
    vs_q.push_back(cyc + LAT + 1);
    tick();
    tick();
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? short_len : HD;
      for (int p = 0; p < len; p++) begin
        per_frame_href  = 1'b1;
        per_frame_clken = 1'b1;
        per_y = 8'(frame_no * 29 + l * 13 + p * 7 + 3);
        e.y   = exp_y(exp_active, per_y);
        e.cyc = cyc + LAT + 1;
        pix_q.push_back(e);
        tick();
      end
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_y = 8'd0;
      for (int g = 0; g < 3; g++) begin
        if (g == 0 && l == wr_line) begin
          cfg_bus.cfg_wr_en = 1'b1;
          cfg_bus.cfg_addr  = wa;
          cfg_bus.cfg_wdata = wd;
          if (wa == 2'd0) tb_shadow = wd & 32'h0000_FF03;
        end
        tick();
        cfg_bus.cfg_wr_en = 1'b0;
      end
    end
    per_frame_vsync = 1'b0;
    for (int g = 0; g < 8; g++) tick();
    frame_no++;
  endtask

  initial begin
    cfg_bus.cfg_wr_en = 1'b0;
    cfg_bus.cfg_rd_en = 1'b0;
    cfg_bus.cfg_addr  = 2'd0;
    cfg_bus.cfg_wdata = 32'd0;
    tick();
    tick();
    tick();
    chk("rst_post_vsync", {31'd0, post_frame_vsync}, 32'd0);
    chk("rst_post_href",  {31'd0, post_frame_href},  32'd0);
    chk("rst_post_clken", {31'd0, post_frame_clken}, 32'd0);
    chk("rst_post_y",     {24'd0, post_y},           32'd0);
    chk("rst_rvalid",     {31'd0, cfg_bus.cfg_rvalid}, 32'd0);
    chk("rst_rdata",      cfg_bus.cfg_rdata,         32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    cfg_read(2'd0, 32'h0000_0001);
    cfg_read(2'd1, 32'h0000_0000);
    cfg_read(2'd2, 32'h0000_0000);
    cfg_read(2'd3, 32'h0000_0000);

    // Filtered frame with nominal geometry
    drive_frame(4, -1, HD, -1, 2'd0, 32'd0);
    cfg_read(2'd1, 32'h0001_0000);
    cfg_read(2'd2, 32'h0004_0008);

    // CTRL=0 written mid-frame: this frame stays filtered, the next is bypassed
    drive_frame(4, -1, HD, 1, 2'd0, 32'h0000_0000);
    drive_frame(4, -1, HD, 2, 2'd0, 32'h0000_A502);
    cfg_read(2'd0, 32'h0000_A502);
    cfg_read(2'd1, 32'h0003_0000);

    // Blanked frame (BVAL=0xA5, bypass timing)
    drive_frame(4, -1, HD, -1, 2'd0, 32'd0);

    // Back to filtered; last line 7 pixels wide
    cfg_write(2'd0, 32'h0000_0001);
    drive_frame(4, 3, 7, -1, 2'd0, 32'd0);
    cfg_read(2'd1, 32'h0005_0002);
    cfg_read(2'd2, 32'h0004_0007);
    cfg_write(2'd1, 32'h0000_0002);
    cfg_read(2'd1, 32'h0005_0000);

    // W1C of HERR in the very cycle a new line error is detected: set wins
    drive_frame(4, 1, 7, 1, 2'd1, 32'h0000_0002);
    cfg_read(2'd1, 32'h0006_0002);
    cfg_read(2'd2, 32'h0004_0008);
    cfg_write(2'd1, 32'h0000_0002);

    // Three-line frame raises VERR; read with simultaneous W1C returns pre-clear value
    drive_frame(3, -1, HD, -1, 2'd0, 32'd0);
    cfg_read(2'd1, 32'h0007_0004);
    cfg_read(2'd2, 32'h0003_0008);
    cfg_rw(2'd1, 32'h0000_0004, 32'h0007_0004);
    cfg_read(2'd1, 32'h0007_0000);

    // Reset asserted mid-line of a partial frame
    cfg_write(2'd0, 32'h0000_3302);
    per_frame_vsync = 1'b1;
    vs_q.push_back(cyc + LAT + 1);
    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      per_y = 8'(p + 8'h40);
      tick();
    end
    rst_n = 1'b0;
    pix_q.delete();
    #1;
    chk("mid_rst_post_vsync", {31'd0, post_frame_vsync}, 32'd0);
    chk("mid_rst_post_href",  {31'd0, post_frame_href},  32'd0);
    chk("mid_rst_post_clken", {31'd0, post_frame_clken}, 32'd0);
    chk("mid_rst_post_y",     {24'd0, post_y},           32'd0);
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_y = 8'd0;
    tb_shadow = 32'h1;
    for (int g = 0; g < 6; g++) tick();
    rst_n = 1'b1;
    tick();
    tick();
    cfg_read(2'd0, 32'h0000_0001);
    cfg_read(2'd1, 32'h0000_0000);
    cfg_read(2'd2, 32'h0000_0000);

    // First complete frame after reset is the first counted
    drive_frame(4, -1, HD, -1, 2'd0, 32'd0);
    cfg_read(2'd1, 32'h0001_0000);
    cfg_read(2'd2, 32'h0004_0008);

    tick();
    tick();
    chk("pix_queue_drained", pix_q.size(), 32'd0);
    chk("vsync_queue_drained", vs_q.size(), 32'd0);
    chk("rd_queue_drained", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
